// File: rtl/simple_logic_pipe.sv
// rtl/simple_logic_pipe.sv - valid/ready pipelined bitwise logic cell with result counter (optional parity: SIMPLE_LOGIC_PIPE_PARITY_EN)
//
// Four WIDTH-bit operands are combined by a mode-selected bitwise function in
// front of stage 0; later stages only move {valid, out, ab, cd} forward.
// Ready ripples combinationally from the output back to in_ready so empty
// stages always accept and a full pipe refills in the cycle it drains.
// Defining SIMPLE_LOGIC_PIPE_PARITY_EN adds out_par, the XOR-reduction of the
// result, computed before stage 0 and carried alongside the data.

module simple_logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_ab,
  output logic [WIDTH-1:0] out_cd,
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] result_cnt
);

  // Stage 0 next-state values produced by the logic function
  logic [WIDTH-1:0] ab_d;
  logic [WIDTH-1:0] cd_d;
  logic [WIDTH-1:0] res_d;

  // Pipeline state, index 0 is nearest the inputs
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  ab_q  [STAGES];
  logic [WIDTH-1:0]  cd_q  [STAGES];

  // What each stage would load: the inputs for stage 0, the previous stage otherwise
  logic [STAGES-1:0] up_valid;
  logic [WIDTH-1:0]  up_res [STAGES];
  logic [WIDTH-1:0]  up_ab  [STAGES];
  logic [WIDTH-1:0]  up_cd  [STAGES];

  // stage_ready[STAGES] is the downstream ready
  logic [STAGES:0] stage_ready;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
  logic              par_d;
  logic [STAGES-1:0] par_q;
  logic [STAGES-1:0] up_par;
`endif

  // Mode-selected bitwise function, evaluated only ahead of stage 0
  always_comb begin
    ab_d  = '0;
    cd_d  = '0;
    res_d = '0;
    case (mode)
      2'b00: begin
        ab_d  = a | b;
        cd_d  = c | d;
        res_d = ab_d & cd_d;
      end
      2'b01: begin
        ab_d  = a & b;
        cd_d  = c & d;
        res_d = ab_d | cd_d;
      end
      2'b10: begin
        ab_d  = a ^ b;
        cd_d  = c ^ d;
        res_d = ab_d ^ cd_d;
      end
      default: begin
        ab_d  = a | b;
        cd_d  = c | d;
        res_d = ~(ab_d & cd_d);
      end
    endcase
  end

`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
  // Parity of the stage 0 result, carried like the data
  always_comb begin
    par_d = ^res_d;
  end
`endif

  // Ready ripples from the output back towards the input; an empty stage always accepts
  always_comb begin
    logic r;
    r = out_ready;
    stage_ready[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r = !valid_q[i] || r;
      stage_ready[i] = r;
    end
  end

  // Upstream source for every stage
  always_comb begin
    up_valid[0] = in_valid;
    up_res[0]   = res_d;
    up_ab[0]    = ab_d;
    up_cd[0]    = cd_d;
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
    up_par[0]   = par_d;
`endif
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = valid_q[i-1];
      up_res[i]   = res_q[i-1];
      up_ab[i]    = ab_q[i-1];
      up_cd[i]    = cd_q[i-1];
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
      up_par[i]   = par_q[i-1];
`endif
    end
  end

  // Stage registers: advance when ready, data only captured alongside a valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
      par_q   <= '0;
`endif
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        ab_q[i]  <= '0;
        cd_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (stage_ready[i]) begin
          valid_q[i] <= up_valid[i];
          if (up_valid[i]) begin
            res_q[i] <= up_res[i];
            ab_q[i]  <= up_ab[i];
            cd_q[i]  <= up_cd[i];
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
            par_q[i] <= up_par[i];
`endif
          end
        end
      end
    end
  end

  // Delivered-result count, wraps naturally at 2^CNT_W
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready   = stage_ready[0];
  assign out_valid  = valid_q[STAGES-1];
  assign out        = res_q[STAGES-1];
  assign out_ab     = ab_q[STAGES-1];
  assign out_cd     = cd_q[STAGES-1];
  assign result_cnt = cnt_q;
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
  assign out_par    = par_q[STAGES-1];
`endif

endmodule

// File: tb/tb_simple_logic_pipe.sv
// tb/tb_simple_logic_pipe.sv - scoreboard bench for simple_logic_pipe (WIDTH=8, STAGES=2)

module tb_simple_logic_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [7:0] a, b, c, d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out, out_ab, out_cd;
  logic [15:0] result_cnt;

  logic       in_ready4, out_valid4;
  logic [7:0] out4, out_ab4, out_cd4;
  logic [3:0] result_cnt4;
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
  logic       out_par, out_par4;
`endif

  always #5 clk = ~clk;

  simple_logic_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_ab(out_ab), .out_cd(out_cd),
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
    .out_par(out_par),
`endif
    .result_cnt(result_cnt)
  );

  simple_logic_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4), .mode(mode),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid4), .out_ready(out_ready),
    .out(out4), .out_ab(out_ab4), .out_cd(out_cd4),
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
    .out_par(out_par4),
`endif
    .result_cnt(result_cnt4)
  );

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] ab;
    logic [7:0] cd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   n_deliv = 0;

  function automatic exp_t model(input logic [1:0] m, input logic [7:0] a_, b_, c_, d_);
    exp_t e;
    case (m)
      2'b00: begin e.ab = a_ | b_; e.cd = c_ | d_; e.res = e.ab & e.cd; end
      2'b01: begin e.ab = a_ & b_; e.cd = c_ & d_; e.res = e.ab | e.cd; end
      2'b10: begin e.ab = a_ ^ b_; e.cd = c_ ^ d_; e.res = e.ab ^ e.cd; end
      default: begin e.ab = a_ | b_; e.cd = c_ | d_; e.res = ~(e.ab & e.cd); end
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: every completed output handshake is compared with the oldest expected entry
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_deliv++;
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got out=%0h ab=%0h cd=%0h expected nothing", out, out_ab, out_cd);
      end else begin
        mon_e = sb.pop_front();
        if ({out, out_ab, out_cd} !== mon_e) begin
          n_bad++;
          $display("FAIL result: got out=%0h ab=%0h cd=%0h expected out=%0h ab=%0h cd=%0h",
                   out, out_ab, out_cd, mon_e.res, mon_e.ab, mon_e.cd);
        end
`ifdef SIMPLE_LOGIC_PIPE_PARITY_EN
        if (out_par !== ^mon_e.res) begin
          n_bad++;
          $display("FAIL out_par: got %0b expected %0b for out=%0h", out_par, ^mon_e.res, mon_e.res);
        end
`endif
      end
    end
  end

  // Present one transaction and hold it until accepted; returns at posedge+1
  task automatic send(input logic [1:0] m, input logic [7:0] a_, b_, c_, d_, input exp_t e);
    in_valid = 1'b1;
    mode = m; a = a_; b = b_; c = c_; d = d_;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
    end
    n_vec++;
    n_bad++;
    $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected an accept");
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0) return;
      @(posedge clk);
      #1;
    end
    n_vec++;
    n_bad++;
    $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    sb.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [7:0] bp_a [3];
  logic [7:0] bp_c [3];
  exp_t bp_e0;
  int   acc, idx, d0;
  logic saw_valid;
  bit   stream_done;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; a = '0; b = '0; c = '0; d = '0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    check("rst_out", {8'd0, out, out_ab, out_cd}, 32'd0);
    check("rst_cnt", {16'd0, result_cnt}, 32'd0);
    reset = 1'b0;

    // Mode sweep; first vector also checks the two-cycle latency
    send(2'b00, 8'hF0, 8'h0C, 8'hAA, 8'h05, '{res: 8'hAC, ab: 8'hFC, cd: 8'hAF});
    in_valid = 1'b0;
    check("latency_edge_n", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("latency_edge_n1", {31'd0, out_valid}, 32'd1);
    send(2'b01, 8'hF0, 8'h0C, 8'hAA, 8'h05, '{res: 8'h00, ab: 8'h00, cd: 8'h00});
    send(2'b10, 8'hF0, 8'h0C, 8'hAA, 8'h05, '{res: 8'h53, ab: 8'hFC, cd: 8'hAF});
    send(2'b11, 8'hF0, 8'h0C, 8'hAA, 8'h05, '{res: 8'h53, ab: 8'hFC, cd: 8'hAF});
    send(2'b00, 8'h01, 8'h00, 8'h01, 8'h00, '{res: 8'h01, ab: 8'h01, cd: 8'h01});
    in_valid = 1'b0;
    drain();
    check("sweep_cnt", {16'd0, result_cnt}, 32'd5);

    // Asynchronous reset with two transactions in flight
    out_ready = 1'b0;
    send(2'b00, 8'h11, 8'h22, 8'h33, 8'h44, model(2'b00, 8'h11, 8'h22, 8'h33, 8'h44));
    send(2'b10, 8'h55, 8'h66, 8'h77, 8'h88, model(2'b10, 8'h55, 8'h66, 8'h77, 8'h88));
    in_valid = 1'b0;
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_out", {8'd0, out, out_ab, out_cd}, 32'd0);
    check("async_cnt", {16'd0, result_cnt}, 32'd0);
    check("async_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    d0 = n_deliv;
    saw_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    @(posedge clk); #1;
    check("no_stale_valid", {31'd0, saw_valid}, 32'd0);
    check("no_stale_deliv", n_deliv - d0, 32'd0);

    // Backpressure: capacity two, held output, same-cycle deliver and accept
    bp_a[0] = 8'h3C; bp_c[0] = 8'h0F;
    bp_a[1] = 8'hA5; bp_c[1] = 8'hF0;
    bp_a[2] = 8'h81; bp_c[2] = 8'h18;
    bp_e0 = model(2'b00, bp_a[0], 8'h00, bp_c[0], 8'h00);
    out_ready = 1'b0;
    acc = 0; idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1; mode = 2'b00;
      a = bp_a[idx]; b = 8'h00; c = bp_c[idx]; d = 8'h00;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(2'b00, bp_a[idx], 8'h00, bp_c[idx], 8'h00));
        idx++;
        acc++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepts", acc, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold", {8'd0, out, out_ab, out_cd}, {8'd0, bp_e0});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd1);
    sb.push_back(model(2'b00, bp_a[2], 8'h00, bp_c[2], 8'h00));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Streaming with random backpressure
    do_reset();
    d0 = n_deliv;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [1:0] m;
          logic [7:0] ra, rb, rc, rd;
          m  = 2'($urandom_range(0, 3));
          ra = 8'($urandom); rb = 8'($urandom);
          rc = 8'($urandom); rd = 8'($urandom);
          send(m, ra, rb, rc, rd, model(m, ra, rb, rc, rd));
        end
        in_valid = 1'b0;
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_deliveries", n_deliv - d0, 32'd100);
    check("stream_cnt", {16'd0, result_cnt}, 32'd100);
    check("stream_cnt4", {28'd0, result_cnt4}, 32'd4);

    // Counter wrap on the CNT_W=4 instance
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(2'b10, 8'(i), 8'h5A, 8'hC3, 8'(i * 3), model(2'b10, 8'(i), 8'h5A, 8'hC3, 8'(i * 3)));
    end
    in_valid = 1'b0;
    drain();
    check("wrap_cnt4", {28'd0, result_cnt4}, 32'd1);
    check("wrap_cnt16", {16'd0, result_cnt}, 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/simple_logic_pipe.md
Name: simple_logic_pipe

Overview:
- Parametrised successor to the team's single-bit registered OR/AND logic cell.
- Takes four WIDTH-bit operands and a per-transaction mode, computes a bitwise logic function, and carries result plus both intermediate terms through STAGES register stages.
- Uses valid/ready handshakes on both sides, so it can sit between pipelined datapath blocks that apply backpressure.
- Keeps a wrapping count of delivered results.

Parameters:
- WIDTH, 8: operand/result width in bits; legal values 1..64.
- STAGES, 2: register stages from input to output; legal values 1..8.
- CNT_W, 16: width of the delivered-result counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/mode valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- mode  in  2  function select, sampled with operands.
- a, b, c, d  in  WIDTH each  operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out  out  WIDTH  result.
- out_ab  out  WIDTH  registered first term, aligned with out.
- out_cd  out  WIDTH  registered second term, aligned with out.
- result_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Function per mode:
  - 00: ab=a|b, cd=c|d, out=ab&cd.
  - 01: ab=a&b, cd=c&d, out=ab|cd.
  - 10: ab=a^b, cd=c^d, out=ab^cd.
  - 11: ab=a|b, cd=c|d, out=~(ab&cd).
- All operations are bitwise, WIDTH bits, with no carries.
- Combinational evaluation happens before stage 0 only. Later stages copy {valid, out, ab, cd} forward unchanged.
- Per-stage ready:
  - stage_ready[i] = !valid[i] || stage_ready[i+1].
  - stage_ready[STAGES] = out_ready.
  - in_ready = stage_ready[0].
  - Bubbles collapse, so an empty stage always accepts.
- Stage i loads from stage i-1 (stage 0 loads from the inputs) when stage_ready[i] is 1.
  - valid[i] takes the upstream valid.
  - Data registers load only when the upstream valid is 1; otherwise they hold.
  - When stage_ready[i] is 0, the stage holds valid and data unchanged.
- Output ports come from the last stage:
  - out_valid = valid[STAGES-1].
  - out, out_ab and out_cd are that stage's data.
  - Outputs are stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - With no backpressure, a transaction accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles of latency.
  - Throughput is one transaction per cycle.
- Capacity: STAGES transactions in flight.
  - When every stage is valid and out_ready=0, in_ready=0.
  - in_ready rises in the same cycle that out_ready rises, because ready is combinational through the stages.
- Simultaneous events: accept and deliver in the same cycle are both honoured and nothing is lost or duplicated.
- Handshake rules:
  - in_valid=1 with in_ready=0 leaves the inputs unsampled. The upstream block must hold them.
  - mode is sampled only on accept.
- result_cnt:
  - Increments by 1 on each edge where out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0.
- Reset (asserted asynchronously):
  - All valid bits, data registers and result_cnt go to 0.
  - Outputs during and after reset: out_valid=0, out=out_ab=out_cd=0, result_cnt=0, in_ready=1.
  - In-flight transactions are discarded; there is no partial delivery.
  - On release, first accept is possible at the first rising edge.

Optional Feature:
- Macro: SIMPLE_LOGIC_PIPE_PARITY_EN.
- When defined:
  - Adds port out_par (out, 1 bit) = XOR-reduction of out, registered at stage 0 and carried with the data.
  - out_par is 0 in reset and held under stall like the other data.
- When undefined: the port and its registers are absent, and all other behaviour is identical.

Test Plan:
- Reset check: reset=1 mid-stream with 2 transactions in flight (WIDTH=8, STAGES=2) -> out_valid=0 and out=0 immediately (asynchronous); result_cnt=0; in_ready=1; no stale result after release.
- Mode sweep with out_ready=1: a=8'hF0, b=8'h0C, c=8'hAA, d=8'h05, driven once per mode -> results appear 2 cycles after each accept, in order:
  - mode 00: out=8'hAC, ab=8'hFC, cd=8'hAF.
  - mode 01: out=8'h00.
  - mode 10: out=8'h53.
  - mode 11: out=8'h53.
- Backpressure: continuous in_valid with out_ready=0 -> exactly STAGES=2 accepts, then in_ready=0. The first output is held stable. Raising out_ready gives a delivery and an accept in the same cycle.
- Streaming with random out_ready, 100 transactions -> scoreboard shows all 100 in order and no duplicates; result_cnt=100.
- Counter wrap: CNT_W=4, 17 deliveries -> result_cnt=1.
- Parity build with SIMPLE_LOGIC_PIPE_PARITY_EN: out=8'hAC -> out_par=0; out=8'h53 -> out_par=0; out=8'h01 -> out_par=1.
